// File: rtl/fb_rect_painter.sv
// ============================================================================
// Module   : fb_rect_painter
// Purpose  : Clipped rectangle fill / screen clear engine streaming one pixel
//            write per clock into the frame buffer write port.
// Options  : PAINTER_OUTLINE_EN - op 10 draws only the rectangle border.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_rect_painter #(
  parameter int SCREEN_X = 184,
  parameter int SCREEN_Y = 184,
  parameter int AW       = 16,
  parameter int DW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [7:0]    cmd_x,
  input  logic [7:0]    cmd_y,
  input  logic [7:0]    cmd_w,
  input  logic [7:0]    cmd_h,
  input  logic [DW-1:0] cmd_color,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr
);

  localparam logic [1:0]    OP_FILL    = 2'b00;
  localparam logic [1:0]    OP_CLEAR   = 2'b01;
  localparam logic [1:0]    OP_OUTLINE = 2'b10;
  localparam logic [1:0]    OP_NOP     = 2'b11;
  localparam logic [8:0]    SX9        = 9'(SCREEN_X);
  localparam logic [8:0]    SY9        = 9'(SCREEN_Y);
  localparam logic [AW-1:0] SX_AW      = AW'(SCREEN_X);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched command
  logic [1:0]    op_lat;
  logic [7:0]    x_lat, y_lat, w_lat, h_lat;
  logic [DW-1:0] color_lat;

  // Iteration state
  logic [8:0]    x_start, x_end, y_end;
  logic [8:0]    col, row;
  logic [AW-1:0] row_base;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  // Holds cmd_ready low for the cycles in which reset is asserted.
  logic          ready_en;

  logic          accept;
  logic          is_clear;
  logic [8:0]    x0, y0;
  logic [8:0]    x_sum, y_sum;
  logic [8:0]    x_end_c, y_end_c;
  logic          area_empty;
  logic          col_last, row_last, last_px;
  logic          pix_en;

  // --------------------------------------------------------------------------
  // Setup arithmetic (9-bit, cannot overflow: 255 + 255 = 510)
  // --------------------------------------------------------------------------
  always_comb begin
    is_clear = (op_lat == OP_CLEAR);
    x_sum    = {1'b0, x_lat} + {1'b0, w_lat};
    y_sum    = {1'b0, y_lat} + {1'b0, h_lat};
    x0       = is_clear ? 9'd0 : {1'b0, x_lat};
    y0       = is_clear ? 9'd0 : {1'b0, y_lat};
    x_end_c  = is_clear ? SX9 : ((x_sum > SX9) ? SX9 : x_sum);
    y_end_c  = is_clear ? SY9 : ((y_sum > SY9) ? SY9 : y_sum);
    area_empty = !is_clear &&
                 ((op_lat == OP_NOP) || (w_lat == 8'd0) || (h_lat == 8'd0) ||
                  ({1'b0, x_lat} >= SX9) || ({1'b0, y_lat} >= SY9));
  end

  always_comb begin
    col_last = ((col + 9'd1) == x_end);
    row_last = ((row + 9'd1) == y_end);
    last_px  = col_last && row_last;
  end

`ifdef PAINTER_OUTLINE_EN
  // Border test uses the unclipped edges so a clipped side stays open.
  logic [8:0] x_edge_r, y_edge_b;

  always_comb begin
    x_edge_r = x_sum - 9'd1;
    y_edge_b = y_sum - 9'd1;
    pix_en   = (op_lat != OP_OUTLINE) ||
               (col == {1'b0, x_lat}) || (col == x_edge_r) ||
               (row == {1'b0, y_lat}) || (row == y_edge_b);
  end
`else
  always_comb begin
    pix_en = 1'b1;
  end
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    px_wr      = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = ready_en;
        if (cmd_valid && ready_en) begin
          accept     = 1'b1;
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        busy       = 1'b1;
        state_next = area_empty ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        busy  = 1'b1;
        px_wr = pix_en;
        if (last_px) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_lat    <= OP_FILL;
      x_lat     <= '0;
      y_lat     <= '0;
      w_lat     <= '0;
      h_lat     <= '0;
      color_lat <= '0;
      x_start   <= '0;
      x_end     <= '0;
      y_end     <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_lat    <= cmd_op;
            x_lat     <= cmd_x;
            y_lat     <= cmd_y;
            w_lat     <= cmd_w;
            h_lat     <= cmd_h;
            color_lat <= cmd_color;
          end
        end
        S_SETUP: begin
          x_start  <= x0;
          x_end    <= x_end_c;
          y_end    <= y_end_c;
          col      <= x0;
          row      <= y0;
          row_base <= AW'(y0) * SX_AW;
          // Output registers only move when pixels will follow, so an
          // empty command leaves the last address/data on the bus.
          if (!area_empty) begin
            addr_q <= AW'(y0) * SX_AW + AW'(x0);
            data_q <= color_lat;
          end
        end
        S_DRAW: begin
          if (!last_px) begin
            if (col_last) begin
              col      <= x_start;
              row      <= row + 9'd1;
              row_base <= row_base + SX_AW;
              addr_q   <= row_base + SX_AW + AW'(x_start);
            end else begin
              col    <= col + 9'd1;
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;

endmodule

`default_nettype wire

// File: tb/tb_fb_rect_painter.sv
// Directed self-checking bench for fb_rect_painter; cycle numbers are counted
// from the accept cycle (cycle 0).
`default_nettype none

module tb_fb_rect_painter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [5:0]  cmd_color = '0;
  logic        busy, done, px_wr;
  logic [15:0] mem_px_addr;
  logic [5:0]  mem_px_data;

  int errors = 0;
  int checks = 0;

  // Per-command capture
  int n_wr, first_wr, done_cyc, done_cnt, ready_cyc, bad_data, oor;
  int wr_addrs[$];

  fb_rect_painter #(.SCREEN_X(184), .SCREEN_Y(184), .AW(16), .DW(6)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .busy(busy), .done(done),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a command in the current cycle and captures everything until
  // cmd_ready returns after done; returns in that ready cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] w, input logic [7:0] h, input logic [5:0] color,
                         input int max_cyc);
    wr_addrs.delete();
    n_wr = 0; first_wr = -1; done_cyc = -1; done_cnt = 0; ready_cyc = -1;
    bad_data = 0; oor = 0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = color;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (px_wr === 1'b1) begin
        wr_addrs.push_back(int'(mem_px_addr));
        n_wr++;
        if (first_wr < 0) first_wr = k;
        if (mem_px_data !== color) bad_data++;
        if (mem_px_addr >= 16'd33856) oor++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (cmd_ready === 1'b1 && done_cyc >= 0) begin
        ready_cyc = k;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if ({cmd_ready, busy, done, px_wr} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/busy/done/wr=%b required 0000",
               {cmd_ready, busy, done, px_wr});
    end
    checks++;
    if (mem_px_addr !== 16'd0 || mem_px_data !== 6'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%0d data=%0h required 0/0", mem_px_addr, mem_px_data);
    end
    rst = 1'b1;
    step();
    step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_fill();
    run_cmd(2'b00, 8'd10, 8'd5, 8'd2, 8'd2, 6'b110000, 50);
    checks++;
    if (n_wr != 4 || wr_addrs.size() != 4) begin
      errors++;
      $display("FAIL fill_count: writes=%0d required 4", n_wr);
    end else begin
      checks++;
      if (wr_addrs[0] != 930 || wr_addrs[1] != 931 || wr_addrs[2] != 1114 || wr_addrs[3] != 1115) begin
        errors++;
        $display("FAIL fill_addr: got %0d,%0d,%0d,%0d required 930,931,1114,1115",
                 wr_addrs[0], wr_addrs[1], wr_addrs[2], wr_addrs[3]);
      end
    end
    checks++;
    if (bad_data != 0) begin
      errors++;
      $display("FAIL fill_data: %0d writes with data != 0x30", bad_data);
    end
    checks++;
    if (first_wr != 2 || done_cyc != 6 || ready_cyc != 7 || done_cnt != 1) begin
      errors++;
      $display("FAIL fill_timing: first=%0d done=%0d ready=%0d pulses=%0d required 2/6/7/1",
               first_wr, done_cyc, ready_cyc, done_cnt);
    end
  endtask

  task automatic test_clip();
    run_cmd(2'b00, 8'd180, 8'd183, 8'd10, 8'd5, 6'h0C, 50);
    checks++;
    if (n_wr != 4 || wr_addrs.size() != 4) begin
      errors++;
      $display("FAIL clip_count: writes=%0d required 4", n_wr);
    end else begin
      checks++;
      if (wr_addrs[0] != 33852 || wr_addrs[1] != 33853 || wr_addrs[2] != 33854 || wr_addrs[3] != 33855) begin
        errors++;
        $display("FAIL clip_addr: got %0d,%0d,%0d,%0d required 33852..33855",
                 wr_addrs[0], wr_addrs[1], wr_addrs[2], wr_addrs[3]);
      end
    end
    checks++;
    if (done_cyc != 6 || oor != 0) begin
      errors++;
      $display("FAIL clip_done: done=%0d out_of_range=%0d required 6/0", done_cyc, oor);
    end
    checks++;
    if (px_wr !== 1'b0 || mem_px_addr !== 16'd33855 || mem_px_data !== 6'h0C) begin
      errors++;
      $display("FAIL clip_hold: wr=%b addr=%0d data=%0h required 0/33855/0c",
               px_wr, mem_px_addr, mem_px_data);
    end
  endtask

  task automatic test_clear();
    int seq_bad;
    seq_bad = 0;
    run_cmd(2'b01, 8'd77, 8'd99, 8'd3, 8'd4, 6'h03, 34000);
    checks++;
    if (n_wr != 33856 || oor != 0 || bad_data != 0) begin
      errors++;
      $display("FAIL clear_count: writes=%0d oor=%0d bad_data=%0d required 33856/0/0",
               n_wr, oor, bad_data);
    end
    for (int i = 0; i < wr_addrs.size(); i++)
      if (wr_addrs[i] != i) seq_bad++;
    checks++;
    if (seq_bad != 0) begin
      errors++;
      $display("FAIL clear_order: %0d out-of-sequence addresses required 0", seq_bad);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 33858) begin
      errors++;
      $display("FAIL clear_done: pulses=%0d cycle=%0d required 1/33858", done_cnt, done_cyc);
    end
  endtask

  task automatic test_empty();
    run_cmd(2'b00, 8'd5, 8'd5, 8'd0, 8'd4, 6'h15, 20);
    checks++;
    if (n_wr != 0 || done_cyc != 2 || ready_cyc != 3) begin
      errors++;
      $display("FAIL empty_w0: writes=%0d done=%0d ready=%0d required 0/2/3", n_wr, done_cyc, ready_cyc);
    end
    run_cmd(2'b00, 8'd200, 8'd5, 8'd10, 8'd4, 6'h15, 20);
    checks++;
    if (n_wr != 0 || done_cyc != 2) begin
      errors++;
      $display("FAIL empty_x200: writes=%0d done=%0d required 0/2", n_wr, done_cyc);
    end
    run_cmd(2'b11, 8'd5, 8'd5, 8'd10, 8'd4, 6'h15, 20);
    checks++;
    if (n_wr != 0 || done_cyc != 2) begin
      errors++;
      $display("FAIL empty_nop: writes=%0d done=%0d required 0/2", n_wr, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    cmd_op = 2'b00; cmd_x = 8'd0; cmd_y = 8'd0; cmd_w = 8'd50; cmd_h = 8'd50; cmd_color = 6'h2A;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (19) step();
    checks++;
    if (px_wr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_active: wr=%b busy=%b at cycle 20 required 1/1", px_wr, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({px_wr, busy, done, cmd_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_abort: wr/busy/done/ready=%b required 0000", {px_wr, busy, done, cmd_ready});
    end
    step();
    rst = 1'b1;
    step();
    step();
    run_cmd(2'b00, 8'd1, 8'd1, 8'd1, 8'd1, 6'h15, 20);
    checks++;
    if (n_wr != 1 || first_wr != 2 || done_cyc != 3 || wr_addrs.size() != 1 || wr_addrs[0] != 185) begin
      errors++;
      $display("FAIL mid_restart: writes=%0d first=%0d done=%0d required 1/2/3 at addr 185",
               n_wr, first_wr, done_cyc);
    end
  endtask

  task automatic test_outline();
    int has185;
    has185 = 0;
    run_cmd(2'b10, 8'd0, 8'd0, 8'd3, 8'd3, 6'h3F, 40);
    foreach (wr_addrs[i]) if (wr_addrs[i] == 185) has185 = 1;
    checks++;
    if (done_cyc != 11) begin
      errors++;
      $display("FAIL outline_done: done=%0d required 11", done_cyc);
    end
    checks++;
`ifdef PAINTER_OUTLINE_EN
    if (n_wr != 8 || has185 != 0) begin
      errors++;
      $display("FAIL outline_writes: writes=%0d has185=%0d required 8/0", n_wr, has185);
    end
`else
    if (n_wr != 9 || has185 != 1) begin
      errors++;
      $display("FAIL outline_writes: writes=%0d has185=%0d required 9/1", n_wr, has185);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int wr_seen;
    run_cmd(2'b00, 8'd0, 8'd2, 8'd1, 8'd1, 6'h01, 20);
    run_cmd(2'b00, 8'd4, 8'd0, 8'd2, 8'd1, 6'h02, 20);
    checks++;
    if (n_wr != 2 || first_wr != 2 || done_cyc != 4 || wr_addrs[0] != 4 || wr_addrs[1] != 5) begin
      errors++;
      $display("FAIL b2b_second: writes=%0d first=%0d done=%0d required 2/2/4 at 4,5",
               n_wr, first_wr, done_cyc);
    end
    // cmd_valid held through a busy command must not be queued
    wr_seen = 0;
    cmd_op = 2'b00; cmd_x = 8'd9; cmd_y = 8'd9; cmd_w = 8'd1; cmd_h = 8'd1; cmd_color = 6'h05;
    cmd_valid = 1'b1;
    step();
    cmd_op = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      if (px_wr === 1'b1) wr_seen++;
      if (k == 3) cmd_valid = 1'b0;
      if (k >= 4 && busy !== 1'b0) wr_seen += 100;
      step();
    end
    checks++;
    if (wr_seen != 1) begin
      errors++;
      $display("FAIL busy_ignore: score=%0d required 1 (one write, idle afterwards)", wr_seen);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_clip();
    test_empty();
    test_outline();
    test_back_to_back();
    test_reset_mid();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
